m706: RTL and testbench
=======================

M706 -- requirements
Module: m706

Interface
REQ-001 SHALL provide parameter DEV_CODE, default 6'o03, the IOT device code this receiver answers to.
REQ-002 SHALL provide parameter OVERSAMPLE, default 8, the number of tick_en pulses per serial bit time; it must be a power of two and at least 4.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port clr_n, input, 1 bit: reset, synchronous, active-low (IO CLEAR / initialize).
REQ-005 SHALL have port tick_en, input, 1 bit: one-clk-wide oversample strobe at OVERSAMPLE x the baud rate.
REQ-006 SHALL have port line_in, input, 1 bit: asynchronous serial line; 1 = mark/idle, 0 = space.
REQ-007 SHALL have port iot, input, 1 bit: an IOT instruction is in execution.
REQ-008 SHALL have port mb_dev, input, 6 bits: the device field, MB[3:8].
REQ-009 SHALL have ports iop1, iop2 and iop4, inputs, 1 bit each: the IOP pulses.
REQ-010 SHALL have port data_out, output, 8 bits: received character gated to the AC bus; 0 when not read.
REQ-011 SHALL have port skip, output, 1 bit: I/O skip request.
REQ-012 SHALL have port ac_clear, output, 1 bit: AC clear request.
REQ-013 SHALL have port flag, output, 1 bit: character-available flag, also the interrupt request.
REQ-014 SHALL have port active, output, 1 bit: a frame is being received.
REQ-015 SHALL have port ferr, output, 1 bit: framing error on the last character.

Function
REQ-016 SHALL define dev_sel = iot & (mb_dev == DEV_CODE).
REQ-017 SHALL synchronise line_in through two flops before any use; the synchronised value is rx.
REQ-018 SHALL implement a four-state FSM (IDLE, START, DATA, STOP), advancing only on clk edges where tick_en = 1.
REQ-019 In IDLE, a tick with rx = 0 SHALL enter START and clear the phase counter; rx = 1 stays in IDLE.
REQ-020 In START, the SHALL sample rx at the tick where phase = OVERSAMPLE/2-1: rx = 0 enters DATA with phase = 0 and bit count = 0; rx = 1 is a false start and returns to IDLE with no flag and no data change.
REQ-021 In DATA, the SHALL shift rx into the shift register LSB-first (shift right, rx into bit 7) at each tick where phase = OVERSAMPLE-1, then increment the bit count; after the 8th bit, the SHALL enter STOP with phase = 0.
REQ-022 In STOP, at phase = OVERSAMPLE-1, the SHALL copy the shift register to the holding buffer, set flag, set ferr = ~rx, and return to IDLE.
REQ-023 The phase counter SHALL be log2(OVERSAMPLE) bits and wrap naturally; the bit count SHALL be 3 bits.
REQ-024 A new start bit SHALL be accepted in the tick immediately after the STOP sample, so that 1 stop bit suffices; extra stop bits are idle.
REQ-025 active SHALL be 1 in START, DATA and STOP.
REQ-026 skip SHALL = dev_sel & iop1 & flag (KSF, combinational).
REQ-027 ac_clear SHALL = dev_sel & iop2 (KCC/KRB).
REQ-028 Any clk with dev_sel & iop2 SHALL clear flag and ferr.
REQ-029 data_out SHALL = holding buffer when dev_sel & iop4 (KRS/KRB), else 8'h00.
REQ-030 On simultaneous flag-set (REQ-022) and flag-clear (REQ-028), set SHALL win, so that no character is lost.
REQ-031 Overrun (a new character completes while flag = 1) SHALL overwrite the buffer and keep flag = 1.
REQ-032 tick_en = 0 SHALL freeze the FSM and counters; IOT logic still operates.

Reset
REQ-033 When clr_n = 0 at a clk edge, the SHALL set FSM = IDLE, phase = 0, bit count = 0, shift register = 0, buffer = 0, flag = 0, ferr = 0, and both synchroniser flops = 1 (mark).
REQ-034 Reset mid-frame SHALL abort the frame with no flag; reception resumes on the next start edge after clr_n = 1.
REQ-035 Outputs after reset SHALL be data_out = 0, skip = 0, ac_clear = 0, flag = 0, active = 0, ferr = 0.

Structure
REQ-036 Package m706_pkg SHALL hold the FSM state enum, DEV_CODE_KBD = 6'o03 and OVERSAMPLE_DEF = 8.
REQ-037 The design SHALL have one sub-module, line_sync (a 2-flop synchroniser with reset value 1); all else is inline.

Verification
REQ-038 With tick_en every 4 clk and OVERSAMPLE = 8, send frame 0x41 with 1 stop bit -> flag = 1 within 8 ticks after the stop-bit midpoint; KRS gives data_out = 8'h41 and ferr = 0.
REQ-039 Send a 2-tick space glitch -> state returns to IDLE, flag stays 0 and the buffer is unchanged.
REQ-040 Send 0xC1 with a space in place of the stop bit -> flag = 1, ferr = 1 and data = 8'hC1; then iop2 clears both.
REQ-041 Send back-to-back 0x55 then 0xAA with no KCC in between -> data_out = 8'hAA, flag = 1; KSF gives skip = 1; with mb_dev = 6'o04, skip = 0 and data_out = 0.
REQ-042 Assert KCC on the exact clk of a stop sample -> flag = 1 after that edge.
REQ-043 Pulse clr_n low at bit 4 of a frame -> active = 0 and flag = 0; the next full frame 0x7F is received correctly.

Source files
------------

// File: rtl/m706_pkg.sv
// Shared definitions for the m706 serial keyboard receiver.
// Holds the receive FSM encoding and the default device code / oversample ratio.
// No logic lives here.
package m706_pkg;

  // Receive FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  localparam logic [5:0] DEV_CODE_KBD   = 6'o03;
  localparam int         OVERSAMPLE_DEF = 8;

endpackage

// File: rtl/m706_line.sv
// Two-flop synchroniser for the asynchronous serial line.
// Latency: 2 clk. Resets to mark (1) so a reset never looks like a start bit.
// No backpressure; free-running.
module line_sync (
  input  logic clk,
  input  logic clr_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Double-register the line; both stages idle at mark
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/m706.sv
// Oversampled async serial receiver with PDP-8 style IOT interface (KSF/KCC/KRS/KRB).
// Latency: flag rises on the clk of the stop-bit sample; IOT outputs are combinational.
// No backpressure: an unread character is overwritten by the next one (flag stays set).
module m706
  import m706_pkg::*;
#(
  parameter logic [5:0] DEV_CODE   = DEV_CODE_KBD,
  parameter int         OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       tick_en,
  input  logic       line_in,
  input  logic       iot,
  input  logic [5:0] mb_dev,
  input  logic       iop1,
  input  logic       iop2,
  input  logic       iop4,
  output logic [7:0] data_out,
  output logic       skip,
  output logic       ac_clear,
  output logic       flag,
  output logic       active,
  output logic       ferr
);

  localparam int            PW      = $clog2(OVERSAMPLE);
  localparam logic [PW-1:0] PH_MID  = PW'(OVERSAMPLE / 2 - 1);
  localparam logic [PW-1:0] PH_LAST = PW'(OVERSAMPLE - 1);

  state_t        state, state_nxt;
  logic [PW-1:0] phase;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic [7:0]    hold_buf;
  logic          rx;
  logic          dev_sel;
  logic          stop_smp;
  logic          kcc;

  line_sync u_sync (
    .clk   (clk),
    .clr_n (clr_n),
    .d     (line_in),
    .q     (rx)
  );

  assign dev_sel  = iot & (mb_dev == DEV_CODE);
  assign kcc      = dev_sel & iop2;
  assign stop_smp = tick_en && (state == ST_STOP) && (phase == PH_LAST);

  // FSM state register
  always_ff @(posedge clk) begin
    if (!clr_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state: only tick clocks move the FSM; start is re-checked at mid start bit
  always_comb begin
    state_nxt = state;
    if (tick_en) begin
      case (state)
        ST_IDLE:  if (!rx) state_nxt = ST_START;
        ST_START: if (phase == PH_MID) state_nxt = rx ? ST_IDLE : ST_DATA;
        ST_DATA:  if (phase == PH_LAST && bit_cnt == 3'd7) state_nxt = ST_STOP;
        ST_STOP:  if (phase == PH_LAST) state_nxt = ST_IDLE;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  // Outputs: status from state, IOT responses decoded combinationally
  always_comb begin
    active   = (state != ST_IDLE);
    skip     = dev_sel & iop1 & flag;
    ac_clear = kcc;
    data_out = (dev_sel & iop4) ? hold_buf : 8'h00;
  end

  // Phase/bit counters, shift register and holding buffer; frozen between ticks
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      phase    <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      hold_buf <= '0;
    end else if (tick_en) begin
      case (state)
        ST_IDLE: begin
          phase   <= '0;
          bit_cnt <= '0;
        end
        ST_START: begin
          if (phase == PH_MID) begin
            phase   <= '0;
            bit_cnt <= '0;
          end else begin
            phase <= phase + 1'b1;
          end
        end
        ST_DATA: begin
          phase <= phase + 1'b1;
          if (phase == PH_LAST) begin
            shreg   <= {rx, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          phase <= phase + 1'b1;
          if (phase == PH_LAST) hold_buf <= shreg;
        end
        default: phase <= '0;
      endcase
    end
  end

  // Flag and framing error: a completing character beats a same-clk KCC
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      flag <= 1'b0;
      ferr <= 1'b0;
    end else if (stop_smp) begin
      flag <= 1'b1;
      ferr <= ~rx;
    end else if (kcc) begin
      flag <= 1'b0;
      ferr <= 1'b0;
    end
  end

endmodule

// File: tb/tb_m706.sv
// Self-checking bench for m706: directed serial frames plus a table of IOT decode vectors.
// One bit time is 8 ticks of 4 clk each (32 clk).
// Outputs are sampled 1 time unit after the falling edge where inputs change.
module tb_m706;
  import m706_pkg::*;

  logic       clk = 1'b0;
  logic       clr_n = 1'b0;
  logic       tick_en = 1'b0;
  logic       line_in = 1'b1;
  logic       iot = 1'b0;
  logic [5:0] mb_dev = 6'o00;
  logic       iop1 = 1'b0;
  logic       iop2 = 1'b0;
  logic       iop4 = 1'b0;
  logic [7:0] data_out;
  logic       skip, ac_clear, flag, active, ferr;

  int checks = 0;
  int errors = 0;
  int tick_cnt = 0;

  typedef struct {
    logic       v_iot;
    logic [5:0] v_dev;
    logic       v_p1, v_p2, v_p4;
    logic [7:0] e_data;
    logic       e_skip;
    logic       e_acc;
  } vec_t;

  vec_t vt[8];

  m706 #(.DEV_CODE(DEV_CODE_KBD), .OVERSAMPLE(8)) dut (
    .clk      (clk),
    .clr_n    (clr_n),
    .tick_en  (tick_en),
    .line_in  (line_in),
    .iot      (iot),
    .mb_dev   (mb_dev),
    .iop1     (iop1),
    .iop2     (iop2),
    .iop4     (iop4),
    .data_out (data_out),
    .skip     (skip),
    .ac_clear (ac_clear),
    .flag     (flag),
    .active   (active),
    .ferr     (ferr)
  );

  always #5 clk = ~clk;

  // One tick every 4 clk
  initial begin
    forever begin
      @(negedge clk);
      tick_en = (tick_cnt == 3);
      tick_cnt = (tick_cnt + 1) % 4;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic iot_set(input logic [5:0] dev, input logic p1, input logic p2, input logic p4);
    iot = 1'b1; mb_dev = dev; iop1 = p1; iop2 = p2; iop4 = p4;
  endtask

  task automatic iot_idle();
    iot = 1'b0; mb_dev = 6'o00; iop1 = 1'b0; iop2 = 1'b0; iop4 = 1'b0;
  endtask

  // KRS read, released before the next rising edge
  task automatic krs_chk(input string name, input logic [7:0] exp);
    @(negedge clk);
    iot_set(DEV_CODE_KBD, 1'b0, 1'b0, 1'b1);
    #1 chk(name, data_out, exp);
    #1 iot_idle();
  endtask

  // KSF probe, released before the next rising edge
  task automatic ksf_chk(input string name, input logic [5:0] dev, input logic exp);
    @(negedge clk);
    iot_set(dev, 1'b1, 1'b0, 1'b0);
    #1 chk(name, skip, exp);
    #1 iot_idle();
  endtask

  // KCC held across one rising edge
  task automatic kcc();
    @(negedge clk);
    iot_set(DEV_CODE_KBD, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    iot_idle();
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_v);
    @(negedge clk);
    line_in = 1'b0;
    repeat (32) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      line_in = d[i];
      repeat (32) @(negedge clk);
    end
    line_in = stop_v;
    repeat (32) @(negedge clk);
    line_in = 1'b1;
  endtask

  initial begin
    logic seen;
    // iot, dev, iop1, iop2, iop4 -> data, skip, ac_clear (buffer 0x41, flag 1)
    vt[0] = '{1'b1, 6'o03, 1'b0, 1'b0, 1'b1, 8'h41, 1'b0, 1'b0};
    vt[1] = '{1'b1, 6'o03, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    vt[2] = '{1'b1, 6'o03, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
    vt[3] = '{1'b0, 6'o03, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};
    vt[4] = '{1'b1, 6'o04, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};
    vt[5] = '{1'b1, 6'o03, 1'b1, 1'b0, 1'b1, 8'h41, 1'b1, 1'b0};
    vt[6] = '{1'b1, 6'o03, 1'b0, 1'b1, 1'b1, 8'h41, 1'b0, 1'b1};
    vt[7] = '{1'b1, 6'o03, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};

    // Reset state
    repeat (4) @(negedge clk);
    #1;
    chk("rst_data_out", data_out, 8'h00);
    chk("rst_skip", skip, 1'b0);
    chk("rst_ac_clear", ac_clear, 1'b0);
    chk("rst_flag", flag, 1'b0);
    chk("rst_active", active, 1'b0);
    chk("rst_ferr", ferr, 1'b0);
    @(negedge clk);
    clr_n = 1'b1;
    krs_chk("rst_buffer", 8'h00);
    repeat (20) @(negedge clk);

    // Clean frame 0x41
    send_frame(8'h41, 1'b1);
    #1;
    chk("f41_flag", flag, 1'b1);
    chk("f41_ferr", ferr, 1'b0);
    chk("f41_active", active, 1'b0);

    // IOT decode table
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      iot_set(vt[i].v_dev, vt[i].v_p1, vt[i].v_p2, vt[i].v_p4);
      iot = vt[i].v_iot;
      #1;
      chk($sformatf("vec%0d_data", i), data_out, vt[i].e_data);
      chk($sformatf("vec%0d_skip", i), skip, vt[i].e_skip);
      chk($sformatf("vec%0d_acc", i), ac_clear, vt[i].e_acc);
      #1 iot_idle();
    end
    @(negedge clk) #1;
    chk("table_flag_kept", flag, 1'b1);
    kcc();
    #1 chk("kcc_flag", flag, 1'b0);
    ksf_chk("ksf_after_kcc", DEV_CODE_KBD, 1'b0);

    // Two-tick space glitch is a false start
    @(negedge clk);
    line_in = 1'b0;
    repeat (8) @(negedge clk);
    line_in = 1'b1;
    repeat (4) @(negedge clk);
    #1 chk("glitch_active_seen", active, 1'b1);
    repeat (40) @(negedge clk);
    #1;
    chk("glitch_active", active, 1'b0);
    chk("glitch_flag", flag, 1'b0);
    krs_chk("glitch_buffer", 8'h41);

    // Framing error: space in the stop position
    send_frame(8'hC1, 1'b0);
    #1;
    chk("fe_flag", flag, 1'b1);
    chk("fe_ferr", ferr, 1'b1);
    krs_chk("fe_data", 8'hC1);
    repeat (40) @(negedge clk);
    #1 chk("fe_idle_after", active, 1'b0);
    kcc();
    #1;
    chk("fe_kcc_flag", flag, 1'b0);
    chk("fe_kcc_ferr", ferr, 1'b0);

    // KCC held through the stop sample: set wins
    seen = 1'b0;
    fork
      send_frame(8'h33, 1'b1);
      begin
        repeat (288) @(negedge clk);
        iot_set(DEV_CODE_KBD, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 64 && !seen; k++) begin
          @(negedge clk);
          #1 if (flag) seen = 1'b1;
        end
        iot_idle();
      end
    join
    chk("race_flag_seen", seen, 1'b1);
    @(negedge clk) #1;
    chk("race_flag_kept", flag, 1'b1);
    krs_chk("race_data", 8'h33);
    kcc();

    // Back-to-back overrun
    send_frame(8'h55, 1'b1);
    send_frame(8'hAA, 1'b1);
    #1 chk("b2b_flag", flag, 1'b1);
    krs_chk("b2b_data", 8'hAA);
    ksf_chk("b2b_ksf", DEV_CODE_KBD, 1'b1);
    @(negedge clk);
    iot_set(6'o04, 1'b1, 1'b0, 1'b1);
    #1;
    chk("b2b_other_skip", skip, 1'b0);
    chk("b2b_other_data", data_out, 8'h00);
    #1 iot_idle();

    // Reset in the middle of bit 4
    @(negedge clk);
    line_in = 1'b0;
    repeat (32 * 5 + 16) @(negedge clk);
    #1 chk("mid_active_before", active, 1'b1);
    clr_n = 1'b0;
    line_in = 1'b1;
    @(negedge clk);
    clr_n = 1'b1;
    #1;
    chk("mid_active", active, 1'b0);
    chk("mid_flag", flag, 1'b0);
    chk("mid_ferr", ferr, 1'b0);
    krs_chk("mid_buffer", 8'h00);
    repeat (64) @(negedge clk);
    send_frame(8'h7F, 1'b1);
    #1;
    chk("f7f_flag", flag, 1'b1);
    chk("f7f_ferr", ferr, 1'b0);
    krs_chk("f7f_data", 8'h7F);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
